// File: rtl/sprite_layer_pkg.sv
// Shared types and constants for the sprite layer compositor.
package sprite_layer_pkg;

  localparam int DEF_NUM_LAYERS  = 4;
  localparam int DEF_PIXEL_W     = 5;
  localparam int DEF_TRANSPARENT = 0;

  typedef logic [DEF_PIXEL_W-1:0] pixel_t;

  // winLayer code reported when the background wins
  localparam logic [3:0] BG_LAYER = 4'hF;

  // True when two or more bits of an (up to 8-layer) opacity vector are set
  function automatic logic multi_hot(input logic [7:0] vec);
    return ((vec & (vec - 8'd1)) != 8'd0);
  endfunction

endpackage

// File: rtl/layer_priority_encoder.sv
// Lowest-index-wins select over the layer opacity vector.
module layer_priority_encoder #(
  parameter int NUM_LAYERS = 4
) (
  input  logic [NUM_LAYERS-1:0] opacity,
  output logic [3:0]            win_idx,
  output logic                  found
);

  // Scan from the top so the lowest opaque index is the last one written
  always_comb begin
    win_idx = 4'd0;
    found   = 1'b0;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      win_idx = opacity[i] ? 4'(i) : win_idx;
      found   = found | opacity[i];
    end
  end

endmodule

// File: rtl/sprite_layer_compositor.sv
// Two-stage sprite layer compositor with optional per-frame overlap
// reporting (compiled in with the SPRITE_COLLISION_EN macro).
module sprite_layer_compositor
  import sprite_layer_pkg::*;
#(
  parameter int NUM_LAYERS  = DEF_NUM_LAYERS,
  parameter int PIXEL_W     = DEF_PIXEL_W,
  parameter int TRANSPARENT = DEF_TRANSPARENT
) (
  input  logic                          Clk,
  input  logic                          Reset_n,
  input  logic                          pixel_en,
  input  logic                          blank,
  input  logic                          VS,
  input  logic [PIXEL_W-1:0]            backgroundPixel,
  input  logic [NUM_LAYERS*PIXEL_W-1:0] layerPixel,
  input  logic [NUM_LAYERS-1:0]         layerOn,
  output logic [PIXEL_W-1:0]            pixelOut,
  output logic [3:0]                    winLayer,
  output logic [NUM_LAYERS-1:0]         collisionOut,
  output logic                          collisionValid
);

  localparam logic [PIXEL_W-1:0] TRANSP_PIX = PIXEL_W'(TRANSPARENT);

  logic [NUM_LAYERS-1:0]         opaque_s;
  logic [NUM_LAYERS-1:0]         opaque_r;
  logic [NUM_LAYERS*PIXEL_W-1:0] layer_pix_r;
  logic [PIXEL_W-1:0]            bg_r;
  logic                          blank_r;
  logic [3:0]                    win_idx_s;
  logic                          found_s;
  logic [PIXEL_W-1:0]            layer_sel_s;
  logic [PIXEL_W-1:0]            comp_pix_s;
  logic [3:0]                    comp_win_s;

  // A layer is opaque when it covers the pixel with a non see-through index
  always_comb begin
    opaque_s = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      opaque_s[i] = layerOn[i] && (layerPixel[i*PIXEL_W +: PIXEL_W] != TRANSP_PIX);
    end
  end

  // Stage 1: capture opacity, pixels, background and blank per pixel strobe
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      opaque_r    <= '0;
      layer_pix_r <= '0;
      bg_r        <= '0;
      blank_r     <= 1'b0;
    end else if (pixel_en) begin
      opaque_r    <= opaque_s;
      layer_pix_r <= layerPixel;
      bg_r        <= backgroundPixel;
      blank_r     <= blank;
    end
  end

  layer_priority_encoder #(
    .NUM_LAYERS (NUM_LAYERS)
  ) u_prio (
    .opacity (opaque_r),
    .win_idx (win_idx_s),
    .found   (found_s)
  );

  // Pick the winning layer's pixel with a one-hot AND-OR mux
  always_comb begin
    layer_sel_s = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      layer_sel_s = layer_sel_s |
                    ((win_idx_s == 4'(i)) ? layer_pix_r[i*PIXEL_W +: PIXEL_W] : '0);
    end
  end

  // Composite result: black during blanking, else winning layer or background
  always_comb begin
    comp_pix_s = '0;
    comp_win_s = BG_LAYER;
    if (!blank_r) begin
      comp_pix_s = '0;
      comp_win_s = BG_LAYER;
    end else if (found_s) begin
      comp_pix_s = layer_sel_s;
      comp_win_s = win_idx_s;
    end else begin
      comp_pix_s = bg_r;
      comp_win_s = BG_LAYER;
    end
  end

  // Stage 2: register composited outputs per pixel strobe
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pixelOut <= '0;
      winLayer <= BG_LAYER;
    end else if (pixel_en) begin
      pixelOut <= comp_pix_s;
      winLayer <= comp_win_s;
    end
  end

`ifdef SPRITE_COLLISION_EN
  logic                  vs_r;
  logic                  frame_end_s;
  logic                  overlap_s;
  logic [NUM_LAYERS-1:0] acc_r;
  logic [NUM_LAYERS-1:0] acc_next_s;

  assign frame_end_s = vs_r & ~VS;

  // Accumulator update including an overlap seen on this very strobe
  always_comb begin
    overlap_s = pixel_en && blank_r && multi_hot(8'(opaque_r));
    if (overlap_s) begin
      acc_next_s = acc_r | opaque_r;
    end else begin
      acc_next_s = acc_r;
    end
  end

  // Registered VS copy for falling-edge (frame end) detection
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      vs_r <= 1'b1;
    end else begin
      vs_r <= VS;
    end
  end

  // Frame accumulator and end-of-frame report
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      acc_r          <= '0;
      collisionOut   <= '0;
      collisionValid <= 1'b0;
    end else if (frame_end_s) begin
      acc_r          <= '0;
      collisionOut   <= acc_next_s;
      collisionValid <= 1'b1;
    end else begin
      acc_r          <= acc_next_s;
      collisionValid <= 1'b0;
    end
  end
`else
  logic unused_vs;
  assign unused_vs      = VS;
  assign collisionOut   = '0;
  assign collisionValid = 1'b0;
`endif

endmodule

// File: doc/sprite_layer_compositor.md
SPRITE_LAYER_COMPOSITOR -- requirements
Module: sprite_layer_compositor

Interface
REQ-001 SHALL have parameter NUM_LAYERS, default 4: number of sprite layers; legal range 1..8.
REQ-002 SHALL have parameter PIXEL_W, default 5: palette-index width of every pixel.
REQ-003 SHALL have parameter TRANSPARENT, default 0: palette index treated as see-through.
REQ-004 Clk  in  1: 50 MHz system clock, single clock domain.
REQ-005 Reset_n  in  1: asynchronous, active-low reset.
REQ-006 pixel_en  in  1: one-Clk strobe per VGA pixel.
REQ-007 blank  in  1: VGA_BLANK_N style; low means blanking interval.
REQ-008 VS  in  1: vertical sync, active low.
REQ-009 backgroundPixel  in  PIXEL_W: scrolled background index.
REQ-010 layerPixel  in  NUM_LAYERS*PIXEL_W: layer i occupies bits [i*PIXEL_W +: PIXEL_W].
REQ-011 layerOn  in  NUM_LAYERS: layer i covers the current DrawX/DrawY.
REQ-012 pixelOut  out  PIXEL_W: composited palette index.
REQ-013 winLayer  out  4: index of the winning layer; 4'hF means background.
REQ-014 collisionOut  out  NUM_LAYERS: per-layer overlap flags for the last completed frame.
REQ-015 collisionValid  out  1: one-Clk pulse when collisionOut updates.

Function
REQ-016 Layer i SHALL be opaque when layerOn[i]=1 and its pixel differs from TRANSPARENT.
REQ-017 Stage 1 SHALL register the opacity vector, the layer pixels, the background pixel and blank, on pixel_en only.
REQ-018 Stage 2 SHALL register pixelOut and winLayer on pixel_en only; total latency is exactly 2 pixel_en strobes.
REQ-019 Priority: lowest-index opaque layer wins; if no layer is opaque, the background wins.
REQ-020 Stage 2 SHALL output pixelOut=0 and winLayer=4'hF when its registered blank is low.
REQ-021 Outputs and pipeline SHALL hold their values while pixel_en=0.
REQ-022 Overlap: at a stage-2 pixel_en with blank high and two or more opaque layers, SHALL OR every opaque layer's bit into a frame accumulator.
REQ-023 Frame end is the VS 1->0 transition, detected with a registered copy of VS.
REQ-024 At frame end, collisionOut SHALL load the accumulator, collisionValid SHALL pulse for one Clk, and the accumulator SHALL clear.
REQ-025 Simultaneous overlap and frame end: the overlap SHALL be included in the latched collisionOut, and the new accumulator SHALL start at zero.
REQ-026 A single opaque layer over an opaque background SHALL NOT count as a collision.
REQ-027 Bits of winLayer above the index range SHALL be zero, except for the 4'hF background code.

Reset
REQ-028 Reset_n low SHALL asynchronously clear:
- both pipeline stages, with blank registered low;
- pixelOut=0 and winLayer=4'hF;
- collisionOut=0, collisionValid=0 and the accumulator;
- the registered VS, which resets to 1.
REQ-029 Reset asserted mid-frame SHALL discard the partial accumulation; the first frame end after reset reports only post-reset overlaps.

Configuration
REQ-030 Macro SPRITE_COLLISION_EN, when defined, SHALL compile in REQ-022..REQ-026.
REQ-031 When SPRITE_COLLISION_EN is undefined:
- collisionOut SHALL tie to 0 and collisionValid to 0;
- no accumulator or VS edge logic SHALL be present;
- compositing is unchanged.

Structure
REQ-032 Package sprite_layer_pkg SHALL hold:
- the pixel_t typedef (PIXEL_W-wide logic);
- the BG_LAYER constant (4'hF);
- the default TRANSPARENT and NUM_LAYERS constants.
REQ-033 Sub-module layer_priority_encoder SHALL hold the combinational lowest-index-wins select (opacity vector to index plus found flag); it is instantiated once, in stage 2.

Verification
REQ-034 Layers 0 and 2 opaque (indices 7 and 9), background 3 -> pixelOut=7 and winLayer=0 exactly 2 pixel_en later.
REQ-035 All layers transparent or off, background 12 -> pixelOut=12, winLayer=4'hF; pixel_en held low for 5 Clk -> outputs unchanged.
REQ-036 blank low with layer 1 opaque -> pixelOut=0, winLayer=4'hF, and no collision bit set.
REQ-037 Layers 1 and 3 overlap once mid-frame, then VS falls -> collisionOut=4'b1010 with a 1-Clk collisionValid pulse; the next clean frame -> collisionOut=0.
REQ-038 Overlap of layers 0 and 1 in the same Clk as the VS fall -> collisionOut=4'b0011, and the following frame reports 0.
REQ-039 Reset_n pulsed low mid-frame after an overlap -> all outputs at reset values immediately; next frame end -> collisionOut=0. Build without SPRITE_COLLISION_EN -> collisionOut stays 0 throughout.
